// File: rtl/vie_sram_like_arbiter.sv
// N-channel SRAM-like request arbiter: merges upstream channels onto one downstream
// req/addr_ok/data_ok bus and routes in-order responses back through an ID FIFO.
module vie_sram_like_arbiter #(
   parameter int NCH         = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int OUTSTANDING = 4,
   parameter int ARB_MODE    = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NCH-1:0]                ch_req,
   input  logic [NCH-1:0]                ch_wr,
   input  logic [2*NCH-1:0]              ch_size,
   input  logic [NCH*DATA_W/8-1:0]       ch_wstrb,
   input  logic [NCH*ADDR_W-1:0]         ch_addr,
   input  logic [NCH*DATA_W-1:0]         ch_wdata,
   output logic [NCH-1:0]                ch_addr_ok,
   output logic [NCH-1:0]                ch_data_ok,
   output logic [DATA_W-1:0]             ch_rdata,
   output logic                          bus_req,
   output logic                          bus_wr,
   output logic [1:0]                    bus_size,
   output logic [DATA_W/8-1:0]           bus_wstrb,
   output logic [ADDR_W-1:0]             bus_addr,
   output logic [DATA_W-1:0]             bus_wdata,
   input  logic                          bus_addr_ok,
   input  logic                          bus_data_ok,
   input  logic [DATA_W-1:0]             bus_rdata,
   output logic [$clog2(OUTSTANDING):0]  outstanding_cnt,
   output logic                          err_spurious
);

   localparam int SW = DATA_W / 8;
   localparam int PW = $clog2(OUTSTANDING);
   localparam int CW = PW + 1;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IW-1:0]   r_lock_id;
   logic [IW-1:0]   w_lock_id_nxt;
   logic [IW-1:0]   r_rr_ptr;
   logic [CW-1:0]   r_cnt;
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [IW-1:0]   r_fifo [OUTSTANDING];
   logic            r_err;

   logic [IW-1:0]   w_arb_id;
   logic [IW-1:0]   w_grant;
   logic [IW-1:0]   w_head_id;
   logic            w_not_full;
   logic            w_push;
   logic            w_pop;

   // Combinational arbitration; only consulted while no grant is locked.
   always_comb begin
      logic [2*NCH-1:0] v_rot2;
      logic [IW:0]      v_ofs;
      logic [IW:0]      v_sum;
      w_arb_id = '0;
      v_rot2   = '0;
      v_ofs    = '0;
      v_sum    = '0;
      if (ARB_MODE == 1 && NCH > 1) begin
         // Rotate so that rr_ptr lands at bit 0, then pick the lowest set bit.
         v_rot2 = {ch_req, ch_req} >> r_rr_ptr;
         for (int k = NCH - 1; k >= 0; k--) begin
            if (v_rot2[k]) v_ofs = (IW+1)'(k);
         end
         v_sum = {1'b0, r_rr_ptr} + v_ofs;
         if (v_sum >= (IW+1)'(NCH)) v_sum = v_sum - (IW+1)'(NCH);
         w_arb_id = v_sum[IW-1:0];
      end else begin
         for (int k = NCH - 1; k >= 0; k--) begin
            if (ch_req[k]) w_arb_id = IW'(k);
         end
      end
   end

   assign w_grant    = (r_state == ST_LOCKED) ? r_lock_id : w_arb_id;
   assign w_not_full = (r_cnt < CW'(OUTSTANDING));
   assign w_head_id  = r_fifo[r_rptr];

   assign bus_req = !reset && ((r_state == ST_LOCKED) || (|ch_req)) && w_not_full;
   assign w_push  = bus_req && bus_addr_ok;
   assign w_pop   = !reset && bus_data_ok && (r_cnt != '0);

   always_comb begin
      bus_wr     = 1'b0;
      bus_size   = '0;
      bus_wstrb  = '0;
      bus_addr   = '0;
      bus_wdata  = '0;
      ch_addr_ok = '0;
      ch_data_ok = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant == IW'(i)) begin
            bus_wr    = ch_wr[i];
            bus_size  = ch_size[2*i +: 2];
            bus_wstrb = ch_wstrb[SW*i +: SW];
            bus_addr  = ch_addr[ADDR_W*i +: ADDR_W];
            bus_wdata = ch_wdata[DATA_W*i +: DATA_W];
         end
         ch_addr_ok[i] = w_push && (w_grant == IW'(i));
         ch_data_ok[i] = w_pop && (w_head_id == IW'(i));
      end
   end

   assign ch_rdata        = bus_rdata;
   assign outstanding_cnt = r_cnt;
   assign err_spurious    = r_err;

   // Grant lock: a request the bus has not yet taken keeps its grant until addr_ok.
   always_comb begin
      w_state_nxt   = r_state;
      w_lock_id_nxt = r_lock_id;
      case (r_state)
         ST_OPEN: begin
            if (bus_req && !bus_addr_ok) begin
               w_state_nxt   = ST_LOCKED;
               w_lock_id_nxt = w_grant;
            end
         end
         ST_LOCKED: begin
            if (bus_addr_ok) w_state_nxt = ST_OPEN;
         end
         default: w_state_nxt = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_OPEN;
         r_lock_id <= '0;
         r_rr_ptr  <= '0;
         r_cnt     <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_id <= w_lock_id_nxt;
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (ARB_MODE == 1 && w_push) begin
            r_rr_ptr <= (w_grant == IW'(NCH - 1)) ? '0 : w_grant + IW'(1);
         end
         if (bus_data_ok && (r_cnt == '0)) r_err <= 1'b1;
      end
   end

   // ID storage is plain data; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr] <= w_grant;
   end

endmodule

// File: tb/tb_vie_sram_like_arbiter.sv
// Directed bench for vie_sram_like_arbiter: one fixed-priority and one round-robin
// instance share the stimulus; each scenario checks the instance it targets.
module tb_vie_sram_like_arbiter;

   localparam int NCH = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int OS  = 4;
   localparam int CW  = $clog2(OS) + 1;

   logic                clk = 1'b0;
   logic                reset;
   logic [NCH-1:0]      ch_req;
   logic [NCH-1:0]      ch_wr;
   logic [2*NCH-1:0]    ch_size;
   logic [NCH*DW/8-1:0] ch_wstrb;
   logic [NCH*AW-1:0]   ch_addr;
   logic [NCH*DW-1:0]   ch_wdata;
   logic                bus_addr_ok;
   logic                bus_data_ok;
   logic [DW-1:0]       bus_rdata;

   logic [NCH-1:0]  d0_addr_ok, d0_data_ok, d1_addr_ok, d1_data_ok;
   logic [DW-1:0]   d0_rdata, d1_rdata, d0_bwdata, d1_bwdata;
   logic            d0_breq, d1_breq, d0_bwr, d1_bwr, d0_err, d1_err;
   logic [1:0]      d0_bsize, d1_bsize;
   logic [DW/8-1:0] d0_bwstrb, d1_bwstrb;
   logic [AW-1:0]   d0_baddr, d1_baddr;
   logic [CW-1:0]   d0_cnt, d1_cnt;

   int n_total = 0;
   int n_bad   = 0;

   localparam logic [AW-1:0] A0 = 32'hBFC0_0000;
   localparam logic [AW-1:0] A1 = 32'h8000_1000;

   always #5 clk = ~clk;

   vie_sram_like_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .OUTSTANDING(OS), .ARB_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
      .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
      .ch_addr_ok(d0_addr_ok), .ch_data_ok(d0_data_ok), .ch_rdata(d0_rdata),
      .bus_req(d0_breq), .bus_wr(d0_bwr), .bus_size(d0_bsize), .bus_wstrb(d0_bwstrb),
      .bus_addr(d0_baddr), .bus_wdata(d0_bwdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .outstanding_cnt(d0_cnt), .err_spurious(d0_err));

   vie_sram_like_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .OUTSTANDING(OS), .ARB_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
      .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
      .ch_addr_ok(d1_addr_ok), .ch_data_ok(d1_data_ok), .ch_rdata(d1_rdata),
      .bus_req(d1_breq), .bus_wr(d1_bwr), .bus_size(d1_bsize), .bus_wstrb(d1_bwstrb),
      .bus_addr(d1_baddr), .bus_wdata(d1_bwdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .outstanding_cnt(d1_cnt), .err_spurious(d1_err));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ch_req      = '0;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      ch_wr    = 2'b10;
      ch_size  = 4'b1010;
      ch_wstrb = 8'hFF;
      ch_addr  = {A1, A0};
      ch_wdata = {32'hCAFE_0001, 32'hCAFE_0000};
      idle_inputs();
      tick();

      // Reset gating of outputs, then reset state
      ch_req = 2'b11; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
      chk("rst_busreq", 32'(d0_breq), 32'd0);
      chk("rst_addrok", 32'(d0_addr_ok), 32'd0);
      chk("rst_dataok", 32'(d0_data_ok), 32'd0);
      do_reset();
      chk("rst_cnt", 32'(d0_cnt), 32'd0);
      chk("rst_err", 32'(d0_err), 32'd0);

      // 1: fixed priority, two accepts then two in-order responses
      ch_req = 2'b11; bus_addr_ok = 1'b1; #1;
      chk("t1_aok0", 32'(d0_addr_ok), 32'h1);
      chk("t1_addr0", d0_baddr, A0);
      chk("t1_size0", 32'(d0_bsize), 32'd2);
      tick();
      ch_req = 2'b10; #1;
      chk("t1_aok1", 32'(d0_addr_ok), 32'h2);
      chk("t1_addr1", d0_baddr, A1);
      chk("t1_wr1", 32'(d0_bwr), 32'd1);
      chk("t1_wdata1", d0_bwdata, 32'hCAFE_0001);
      tick();
      ch_req = 2'b00; bus_addr_ok = 1'b0; #1;
      chk("t1_cnt2", 32'(d0_cnt), 32'd2);
      bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111; #1;
      chk("t1_dok0", 32'(d0_data_ok), 32'h1);
      chk("t1_rdata0", d0_rdata, 32'h1111_1111);
      tick();
      bus_rdata = 32'h2222_2222; #1;
      chk("t1_dok1", 32'(d0_data_ok), 32'h2);
      chk("t1_rdata1", d0_rdata, 32'h2222_2222);
      tick();
      bus_data_ok = 1'b0; #1;
      chk("t1_cnt0", 32'(d0_cnt), 32'd0);

      // 2: round-robin alternation, responses keep the FIFO from filling
      do_reset();
      ch_req = 2'b11; bus_addr_ok = 1'b1; #1;
      chk("t2_g0", 32'(d1_addr_ok), 32'h1);
      tick();
      bus_data_ok = 1'b1; #1;
      chk("t2_g1", 32'(d1_addr_ok), 32'h2);
      chk("t2_dok_c1", 32'(d1_data_ok), 32'h1);
      tick(); #1;
      chk("t2_g2", 32'(d1_addr_ok), 32'h1);
      chk("t2_dok_c2", 32'(d1_data_ok), 32'h2);
      tick(); #1;
      chk("t2_g3", 32'(d1_addr_ok), 32'h2);
      tick(); #1;
      chk("t2_g4_rrwrap", 32'(d1_addr_ok), 32'h1);
      chk("t2_cnt", 32'(d1_cnt), 32'd1);
      chk("t2_fixed_prio_g4", 32'(d0_addr_ok), 32'h1);

      // 3: grant lock holds ch1 against a later ch0 request
      do_reset();
      ch_req = 2'b10; bus_addr_ok = 1'b0; #1;
      chk("t3_addr_c0", d0_baddr, A1);
      chk("t3_req_c0", 32'(d0_breq), 32'd1);
      chk("t3_aok_c0", 32'(d0_addr_ok), 32'h0);
      tick();
      ch_req = 2'b11; #1;
      chk("t3_addr_c1", d0_baddr, A1);
      tick(); #1;
      chk("t3_addr_c2", d0_baddr, A1);
      tick();
      bus_addr_ok = 1'b1; #1;
      chk("t3_addr_c3", d0_baddr, A1);
      chk("t3_aok_c3", 32'(d0_addr_ok), 32'h2);
      tick();
      ch_req = 2'b01; #1;
      chk("t3_aok_c4", 32'(d0_addr_ok), 32'h1);
      chk("t3_addr_c4", d0_baddr, A0);
      tick();

      // 4: full limiter
      do_reset();
      ch_req = 2'b01; bus_addr_ok = 1'b1;
      for (int i = 0; i < OS; i++) tick();
      #1;
      chk("t4_cnt_full", 32'(d0_cnt), 32'd4);
      chk("t4_req_full", 32'(d0_breq), 32'd0);
      chk("t4_aok_full", 32'(d0_addr_ok), 32'h0);
      bus_data_ok = 1'b1; bus_rdata = 32'h4444_4444; #1;
      chk("t4_dok", 32'(d0_data_ok), 32'h1);
      chk("t4_req_poppingcyc", 32'(d0_breq), 32'd0);
      tick();
      bus_data_ok = 1'b0; #1;
      chk("t4_cnt3", 32'(d0_cnt), 32'd3);
      chk("t4_req_after_pop", 32'(d0_breq), 32'd1);
      chk("t4_aok_after_pop", 32'(d0_addr_ok), 32'h1);
      tick();
      ch_req = 2'b00; #1;
      chk("t4_cnt_refull", 32'(d0_cnt), 32'd4);

      // 5: simultaneous accept and response at cnt=2, routed to the oldest ID
      do_reset();
      ch_req = 2'b10; bus_addr_ok = 1'b1;
      tick();
      ch_req = 2'b01;
      tick(); #1;
      chk("t5_cnt2", 32'(d0_cnt), 32'd2);
      bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555; #1;
      chk("t5_dok_oldest", 32'(d0_data_ok), 32'h2);
      chk("t5_aok", 32'(d0_addr_ok), 32'h1);
      tick();
      ch_req = 2'b00; bus_addr_ok = 1'b0; #1;
      chk("t5_cnt_same", 32'(d0_cnt), 32'd2);
      chk("t5_dok_next", 32'(d0_data_ok), 32'h1);
      tick(); #1;
      chk("t5_dok_last", 32'(d0_data_ok), 32'h1);
      tick(); #1;

      // 6: spurious response, then reset discards in-flight IDs
      chk("t6_cnt0", 32'(d0_cnt), 32'd0);
      chk("t6_dok_spur", 32'(d0_data_ok), 32'h0);
      tick();
      bus_data_ok = 1'b0; #1;
      chk("t6_err_set", 32'(d0_err), 32'd1);
      tick(); #1;
      chk("t6_err_sticky", 32'(d0_err), 32'd1);
      ch_req = 2'b01; bus_addr_ok = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      ch_req = 2'b00; bus_addr_ok = 1'b0; #1;
      chk("t6_cnt3", 32'(d0_cnt), 32'd3);
      reset = 1'b1; ch_req = 2'b01; #1;
      chk("t6_req_in_rst", 32'(d0_breq), 32'd0);
      tick(); #1;
      chk("t6_cnt_rst", 32'(d0_cnt), 32'd0);
      chk("t6_err_rst", 32'(d0_err), 32'd0);
      chk("t6_req_rst", 32'(d0_breq), 32'd0);
      reset = 1'b0; ch_req = 2'b00; bus_data_ok = 1'b1; #1;
      chk("t6_late_dok", 32'(d0_data_ok), 32'h0);
      tick();
      bus_data_ok = 1'b0; #1;
      chk("t6_late_err", 32'(d0_err), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
